// File: rtl/cs_bist.sv
// cs_bist: self-test driver for the approximate-averaging CS core.
// Drives an LFSR-generated 8-bit sample stream on X and compacts the
// 10-bit CS results on Y into a 16-bit MISR signature once the sample
// window is full. Reports completion on done.
//
// Optional build macro: CS_BIST_COMPARE_EN
//   defined   - registers pass = (signature == EXP_SIG) on entry to DONE
//   undefined - no comparator; pass is tied to 0 and EXP_SIG is unused
//
// Capture handshake: y_valid is a pure qualifier with no back-pressure.
// Whenever y_valid is high, the Y value present in that cycle is folded
// into the signature at the closing posedge; Y is ignored otherwise.
// The FSM state is held in the `state` signal (state_t) for observation.

module cs_bist #(
  parameter int          N_PAT   = 2000,
  parameter int          LATENCY = 9,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter logic [15:0] EXP_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  X,
  input  logic [9:0]  Y,
  output logic        busy,
  output logic        y_valid,
  output logic        done,
  output logic [15:0] pat_cnt,
  output logic [15:0] signature,
  output logic        pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last pat_cnt of a run (final capture), last index that advances X,
  // first index at which Y is valid.
  localparam logic [15:0] LAST_CNT   = 16'(N_PAT);
  localparam logic [15:0] LAST_X_CNT = 16'(N_PAT - 1);
  localparam logic [15:0] LAT_CNT    = 16'(LATENCY);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]  SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] SIG_INIT   = 16'hFFFF;
  localparam logic [15:0] MISR_POLY  = 16'h1021;

  state_t state;
  state_t state_nxt;

  logic        start_ok;
  logic        at_end;
  logic [15:0] cnt_inc;
  logic [7:0]  lfsr_next;
  logic [15:0] misr_next;

  logic [7:0]  x_nxt;
  logic [15:0] cnt_nxt;
  logic [15:0] sig_nxt;
  logic        yv_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  // abort outranks start, including when idle or done.
  assign start_ok  = start & ~abort;
  assign at_end    = (pat_cnt == LAST_CNT);
  assign cnt_inc   = pat_cnt + 16'd1;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1.
  assign lfsr_next = {X[6:0], X[7] ^ X[5] ^ X[4] ^ X[3]};

  // MISR with CRC-CCITT feedback; Y enters on the low bits.
  assign misr_next = {signature[14:0], 1'b0}
                   ^ (signature[15] ? MISR_POLY : 16'h0000)
                   ^ {6'b0, Y};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start launches a run, abort cancels it, the final
  // capture moves to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)       state_nxt = ST_IDLE;
        else if (at_end) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    x_nxt    = X;
    cnt_nxt  = pat_cnt;
    sig_nxt  = signature;
    yv_nxt   = 1'b0;
    done_nxt = done;
    busy_nxt = (state_nxt == ST_RUN);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          x_nxt    = SEED_EFF;
          cnt_nxt  = 16'd0;
          sig_nxt  = SIG_INIT;
          done_nxt = 1'b0;
          yv_nxt   = (LAT_CNT == 16'd0);
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Partial signature and current X/pat_cnt are left as they are.
          done_nxt = 1'b0;
        end else begin
          if (y_valid) sig_nxt = misr_next;
          if (at_end) begin
            done_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
            yv_nxt  = (cnt_inc >= LAT_CNT) && (cnt_inc <= LAST_CNT);
            // X stops advancing once the last sample has been issued and
            // holds through the final capture cycle.
            if (pat_cnt < LAST_X_CNT) x_nxt = lfsr_next;
          end
        end
      end
      default: begin
        done_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs; every port comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      X         <= 8'h00;
      pat_cnt   <= 16'd0;
      signature <= SIG_INIT;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      X         <= x_nxt;
      pat_cnt   <= cnt_nxt;
      signature <= sig_nxt;
      y_valid   <= yv_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

`ifdef CS_BIST_COMPARE_EN
  logic pass_nxt;

  // Pass flag: evaluated against the final signature on entry to DONE,
  // cleared when a run starts or is aborted.
  always_comb begin
    pass_nxt = pass;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) pass_nxt = 1'b0;
      end
      ST_RUN: begin
        if (abort)       pass_nxt = 1'b0;
        else if (at_end) pass_nxt = (sig_nxt == EXP_SIG);
      end
      default: pass_nxt = 1'b0;
    endcase
  end

  // Pass register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass <= 1'b0;
    end else begin
      pass <= pass_nxt;
    end
  end
`else
  logic unused_exp_sig;

  // No comparator in this build.
  assign pass           = 1'b0;
  assign unused_exp_sig = ^EXP_SIG;
`endif

endmodule

// File: tb/tb_cs_bist.sv
// tb_cs_bist: checks three cs_bist instances sharing one stimulus stream
// (short run with seed A5, short run with seed 0, default-length run)
// against a behavioural model built from the sample/capture rules.

module tb_cs_bist;

  localparam int          LAT        = 9;
  localparam int          P_N   [3]  = '{10, 10, 2000};
  localparam logic [7:0]  P_SEED[3]  = '{8'hA5, 8'h00, 8'hA5};
  localparam logic [15:0] P_EXP [3]  = '{16'hCF9F, 16'hCF9E, 16'h0000};
`ifdef CS_BIST_COMPARE_EN
  localparam bit          CMP_EN     = 1'b1;
`else
  localparam bit          CMP_EN     = 1'b0;
`endif

  localparam int MS_IDLE = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_DONE = 2;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] y     = 10'd0;

  always #5 clk = ~clk;

  logic [7:0]  x_a, x_b, x_c;
  logic        busy_a, busy_b, busy_c;
  logic        yv_a, yv_b, yv_c;
  logic        done_a, done_b, done_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [15:0] sig_a, sig_b, sig_c;
  logic        pass_a, pass_b, pass_c;

  cs_bist #(.N_PAT(10), .LATENCY(LAT), .SEED(8'hA5), .EXP_SIG(16'hCF9F)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .X(x_a), .Y(y),
    .busy(busy_a), .y_valid(yv_a), .done(done_a), .pat_cnt(cnt_a),
    .signature(sig_a), .pass(pass_a));

  cs_bist #(.N_PAT(10), .LATENCY(LAT), .SEED(8'h00), .EXP_SIG(16'hCF9E)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .X(x_b), .Y(y),
    .busy(busy_b), .y_valid(yv_b), .done(done_b), .pat_cnt(cnt_b),
    .signature(sig_b), .pass(pass_b));

  cs_bist dut_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .X(x_c), .Y(y),
    .busy(busy_c), .y_valid(yv_c), .done(done_c), .pat_cnt(cnt_c),
    .signature(sig_c), .pass(pass_c));

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_st   [3];
  int          m_k    [3];
  logic [15:0] m_sig  [3];
  logic        m_pass [3];
  logic        m_fresh[3];  // since reset: X and pat_cnt are still 0
  logic        m_known[3];  // X/pat_cnt defined (not after an abort)

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [15:0] misr_fold(input logic [15:0] s, input logic [9:0] yy);
    logic [15:0] r;
    r = s << 1;
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {6'd0, yy};
  endfunction

  function automatic logic [7:0] seed_eff(input int d);
    return (P_SEED[d] == 8'h00) ? 8'h01 : P_SEED[d];
  endfunction

  // k-th LFSR state from the seed, cached so successive calls are cheap.
  logic [7:0] xc_val[3];
  int         xc_k  [3];

  function automatic logic [7:0] exp_x(input int d, input int k);
    if (k < xc_k[d]) begin
      xc_k[d]   = 0;
      xc_val[d] = seed_eff(d);
    end
    while (xc_k[d] < k) begin
      xc_val[d] = lfsr_step(xc_val[d]);
      xc_k[d]++;
    end
    return xc_val[d];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 3; d++) begin
        m_st[d]    <= MS_IDLE;
        m_k[d]     <= 0;
        m_sig[d]   <= 16'hFFFF;
        m_pass[d]  <= 1'b0;
        m_fresh[d] <= 1'b1;
        m_known[d] <= 1'b1;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (m_st[d] == MS_RUN) begin
          if (abort) begin
            m_st[d]    <= MS_IDLE;
            m_known[d] <= 1'b0;
          end else begin
            if (m_k[d] >= LAT && m_k[d] <= P_N[d]) m_sig[d] <= misr_fold(m_sig[d], y);
            if (m_k[d] == P_N[d]) begin
              m_st[d]   <= MS_DONE;
              m_pass[d] <= CMP_EN && (misr_fold(m_sig[d], y) == P_EXP[d]);
            end else begin
              m_k[d] <= m_k[d] + 1;
            end
          end
        end else if (start && !abort) begin
          m_st[d]    <= MS_RUN;
          m_k[d]     <= 0;
          m_sig[d]   <= 16'hFFFF;
          m_pass[d]  <= 1'b0;
          m_fresh[d] <= 1'b0;
          m_known[d] <= 1'b1;
        end
      end
    end
  end

  function automatic bit any_run();
    bit r = 1'b0;
    for (int d = 0; d < 3; d++) if (m_st[d] == MS_RUN) r = 1'b1;
    return r;
  endfunction

  task automatic check_dut(input int d, input logic [7:0] x, input logic bz, input logic yv,
                           input logic dn, input logic [15:0] cnt, input logic [15:0] sg,
                           input logic ps);
    string p;
    int    kk;
    bit    run;
    p   = $sformatf("d%0d", d);
    run = (m_st[d] == MS_RUN);
    check_eq({p, "_busy"}, bz, run);
    check_eq({p, "_done"}, dn, m_st[d] == MS_DONE);
    check_eq({p, "_yvalid"}, yv, run && m_k[d] >= LAT && m_k[d] <= P_N[d]);
    check_eq({p, "_sig"}, sg, m_sig[d]);
    check_eq({p, "_pass"}, ps, m_pass[d]);
    if (m_known[d]) begin
      kk = (m_k[d] < P_N[d]) ? m_k[d] : P_N[d] - 1;
      check_eq({p, "_patcnt"}, cnt, m_fresh[d] ? 0 : m_k[d]);
      check_eq({p, "_x"}, x, m_fresh[d] ? 8'h00 : exp_x(d, kk));
    end
  endtask

  task automatic check_all();
    check_dut(0, x_a, busy_a, yv_a, done_a, cnt_a, sig_a, pass_a);
    check_dut(1, x_b, busy_b, yv_b, done_b, cnt_b, sig_b, pass_b);
    check_dut(2, x_c, busy_c, yv_c, done_c, cnt_c, sig_c, pass_c);
  endtask

  // ---------------- driver tasks ----------------
  int         cyc    = 0;
  int         y_mode = 0;   // 0: zero, 1: CS stand-in, 2: random
  logic [7:0] x_hist[$];

  // Stand-in for CS: scaled sum of the last nine samples seen on X.
  function automatic logic [9:0] cs_y();
    int s = 0;
    foreach (x_hist[i]) s += x_hist[i];
    return 10'(s >> 2);
  endfunction

  // Apply inputs just after a negedge, then check at the next negedge.
  task automatic cycle(input logic s, input logic a);
    start = s;
    abort = a;
    x_hist.push_back(x_c);
    if (x_hist.size() > 9) void'(x_hist.pop_front());
    case (y_mode)
      0:       y = 10'd0;
      1:       y = cs_y();
      default: y = 10'($urandom_range(0, 1023));
    endcase
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic launch();
    cyc = -1;
    cycle(1'b1, 1'b0);
  endtask

  task automatic run_to_end();
    int budget = 2100;
    while (any_run() && budget > 0) begin
      cycle(1'b0, 1'b0);
      budget--;
    end
    check_eq("run_end_timeout", any_run(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      xc_k[d]   = 0;
      xc_val[d] = seed_eff(d);
    end

    // Reset held while the clock runs.
    repeat (3) @(negedge clk);
    check_all();
    check_eq("rst_sig", sig_a, 16'hFFFF);
    check_eq("rst_x", x_c, 8'h00);
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_eq("idle_busy", busy_a, 1'b0);

    // Run with Y tied to 0; start held through cycle 5 has no effect.
    y_mode = 0;
    launch();
    check_eq("lfsr_c0", x_a, 8'hA5);
    check_eq("seed0_c0", x_b, 8'h01);
    for (int c = 1; c <= 11; c++) begin
      cycle(c <= 5, 1'b0);
      case (c)
        1:  check_eq("lfsr_c1", x_a, 8'h4A);
        2:  check_eq("lfsr_c2", x_a, 8'h95);
        5:  check_eq("start_ignored_cnt", cnt_a, 16'd5);
        8:  check_eq("yv_c8", yv_a, 1'b0);
        9:  check_eq("yv_c9", yv_a, 1'b1);
        10: begin
          check_eq("yv_c10", yv_a, 1'b1);
          check_eq("sig_c10", sig_a, 16'hEFDF);
        end
        11: begin
          check_eq("yv_c11", yv_a, 1'b0);
          check_eq("sig_c11", sig_a, 16'hCF9F);
          check_eq("done_c11", done_a, 1'b1);
          check_eq("busy_c11", busy_a, 1'b0);
          check_eq("pass_match", pass_a, CMP_EN);
          check_eq("pass_mismatch", pass_b, 1'b0);
        end
        default: ;
      endcase
    end
    run_to_end();

    // Abort outranks start from DONE.
    cycle(1'b1, 1'b1);
    check_eq("abort_beats_start", done_a, 1'b1);

    // Abort at pat_cnt=5.
    launch();
    repeat (5) cycle(1'b0, 1'b0);
    check_eq("abort_cnt5", cnt_a, 16'd5);
    cycle(1'b0, 1'b1);
    check_eq("abort_busy", busy_a, 1'b0);
    check_eq("abort_done", done_a, 1'b0);
    cycle(1'b0, 1'b0);

    // Restart after abort.
    launch();
    check_eq("restart_sig", sig_a, 16'hFFFF);
    check_eq("restart_x", x_a, 8'hA5);
    check_eq("restart_cnt", cnt_c, 16'd0);
    run_to_end();

    // Two consecutive full runs with a deterministic CS stand-in.
    y_mode = 1;
    x_hist.delete();
    launch();
    run_to_end();
    exp_q.push_back(sig_c);
    x_hist.delete();
    launch();
    run_to_end();
    check_eq("rerun_sig", sig_c, exp_q.pop_front());

    // Random Y with occasional aborts before the first capture.
    y_mode = 2;
    repeat (4) begin
      int ab_at;
      ab_at = $urandom_range(0, 15);
      launch();
      if (ab_at <= 8) begin
        while (cyc < ab_at) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
      end else begin
        run_to_end();
      end
    end

    // Asynchronous reset mid-run.
    launch();
    repeat (500) cycle(1'b0, 1'b0);
    start = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all();
    check_eq("async_busy", busy_c, 1'b0);
    check_eq("async_cnt", cnt_c, 16'd0);
    check_eq("async_sig", sig_c, 16'hFFFF);
    check_eq("async_x", x_c, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_bist.md
# cs_bist

Built-in self-test driver for the approximate-averaging `CS` core. It generates the 8-bit `X` sample stream from an LFSR and compacts the 10-bit `Y` results into a 16-bit MISR signature once the 9-sample window is full. It then reports completion and, optionally, pass/fail. It sits beside `CS` on the same clock: `X` drives `CS.X` and `CS.Y` returns into `Y`, so it is the stimulus and capture end of that interface.

## Interface
- `N_PAT`, 2000: number of X samples driven per run (must be > `LATENCY`).
- `LATENCY`, 9: samples needed before the first valid `Y`.
- `SEED`, 8'hA5: LFSR seed; a value of 0 is replaced by 8'h01.
- `EXP_SIG`, 16'h0000: expected final signature (used only with `CS_BIST_COMPARE_EN`).
- `clk`  in  1: rising-edge clock shared with `CS`.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: run request, sampled at posedge.
- `abort`  in  1: cancels the current run.
- `X`  out  8: sample to `CS`.
- `Y`  in  10: result from `CS`.
- `busy`  out  1: a run is in progress.
- `y_valid`  out  1: `Y` is captured this cycle.
- `done`  out  1: the run completed; level signal.
- `pat_cnt`  out  16: index of the current sample.
- `signature`  out  16: MISR contents.
- `pass`  out  1: `signature == EXP_SIG` when `done` is high.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values (reset low): state=IDLE, `X`=0, `busy`=0, `y_valid`=0, `done`=0, `pat_cnt`=0, `signature`=16'hFFFF, `pass`=0.
- IDLE or DONE with `start`=1 at a posedge:
  - next state RUN.
  - `X`=SEED (or 8'h01 if SEED is 0), `pat_cnt`=0, `signature`=16'hFFFF, `done`=0.
- RUN, cycle k (`pat_cnt`=k):
  - While k < N_PAT-1, each posedge advances the LFSR into `X` and increments `pat_cnt`.
  - At k=N_PAT-1 `X` holds its value, and it keeps holding through cycle N_PAT.
- LFSR: Fibonacci, x^8+x^6+x^5+x^4+1. Next value = {X[6:0], X[7]^X[5]^X[4]^X[3]}.
- `y_valid` = RUN && LATENCY ≤ `pat_cnt` ≤ N_PAT. Capture count per run = N_PAT-LATENCY+1 (1992 at defaults).
- MISR update at a posedge where `y_valid`=1: sig ← {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {6'b0,Y}.
- After the capture at `pat_cnt`=N_PAT: state DONE, `busy`=0, `done`=1. `signature` and `pat_cnt` are frozen until the next start.
- `abort`=1 at a posedge in RUN → IDLE. `done` stays 0 and `signature` keeps its partial value. `abort` outranks `start`.
- `start` during RUN is ignored.
- Reset asserted mid-run takes every output to its reset value immediately (asynchronous).

## Timing
- `X` changes only just after a posedge. `CS` captures sample k at the posedge that ends cycle k.
- The first `Y` capture is at the end of cycle LATENCY. It covers samples 0..LATENCY-1.
- Run length is N_PAT+1 cycles from the first RUN cycle. `done` rises in the following cycle.
- `busy` = (state==RUN) and is registered. All outputs come directly from registers.

## Configuration
- `CS_BIST_COMPARE_EN` defined:
  - An on-entry-to-DONE compare registers `pass` = (`signature`==EXP_SIG).
  - `pass` is cleared on start, abort and reset.
- `CS_BIST_COMPARE_EN` undefined:
  - No comparator is built and `pass` is tied to 0.
  - `EXP_SIG` is unused.

## Test plan
- Reset: hold `reset`=0, toggle `clk` → all outputs at their reset values, including `signature`=FFFF. Release reset → state IDLE with no activity.
- LFSR sequence: SEED=A5, pulse `start` → `X` = A5, 4A, 95 in cycles 0, 1, 2. Set SEED=0 → first `X`=01.
- MISR and done timing: N_PAT=10, LATENCY=9, `Y` tied to 0:
  - `y_valid` is high in cycles 9 and 10 only.
  - `signature` goes EFDF then CF9F.
  - `done`=1 in cycle 11 and `busy`=0.
- Compare: same as the previous scenario with EXP_SIG=CF9F → `pass`=1. With EXP_SIG=CF9E → `pass`=0. Without the macro → `pass`=0 always.
- Abort and restart:
  - `abort` at `pat_cnt`=5 → IDLE next cycle, `done`=0.
  - `start` held during RUN has no effect.
  - A new `start` → `signature` restarts at FFFF and `X` at SEED.
- Full run with `CS`: defaults, `CS` connected → 1992 captures. Two consecutive runs give identical signatures. An asynchronous reset pulse mid-run clears all outputs within the same cycle.
